// File: rtl/paraleloserie_idle_tx_pkg.sv
// Constants and types shared by the lane transmitter and its serieparalelo_IDLE receiver.
// The IDLE/COM symbol and the training length must match on both ends of the lane.
package paraleloserie_idle_tx_pkg;

   localparam int         WIDTH    = 8;
   localparam logic [7:0] IDLE_SYM = 8'hBC;
   localparam int         N_IDLE   = 4;

   typedef enum logic {
      ST_TRAIN,
      ST_SYNCED
   } tx_state_t;

   // Width of a counter that must hold values 0..n-1, never narrower than one bit.
   function automatic int cnt_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/paraleloserie_idle_tx_piso_shifter.sv
// Bit counter and MSB-first shift register; raises load_edge on the cycle that takes a new symbol.
// A low reset drops whatever partial symbol is in flight and re-arms the next edge as a load.
module piso_shifter #(
   parameter int WIDTH = paraleloserie_idle_tx_pkg::WIDTH
) (
   input  logic             clk32f,
   input  logic             reset,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_edge,
   output logic             out
);
   import paraleloserie_idle_tx_pkg::*;

   localparam int            CW   = cnt_bits(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [CW-1:0]    bit_cnt;
   logic [WIDTH-2:0] sh;

   assign load_edge = (bit_cnt == LAST);

   // The MSB goes straight to out on the load edge, so sh only has to hold the remaining bits.
   always_ff @(posedge clk32f) begin
      if (!reset) begin
         out     <= 1'b0;
         bit_cnt <= LAST;
         sh      <= '0;
      end else if (load_edge) begin
         out     <= load_data[WIDTH-1];
         sh      <= load_data[WIDTH-2:0];
         bit_cnt <= '0;
      end else begin
         out     <= sh[WIDTH-2];
         sh      <= sh << 1;
         bit_cnt <= bit_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/paraleloserie_idle_tx.sv
// Lane transmitter: sends N_IDLE training IDLE symbols after reset, then upstream bytes or IDLE fill.
// The training counter and the data/IDLE select live here; serialisation is in piso_shifter.
module paraleloserie_idle_tx #(
   parameter int               WIDTH    = paraleloserie_idle_tx_pkg::WIDTH,
   parameter logic [WIDTH-1:0] IDLE_SYM = paraleloserie_idle_tx_pkg::IDLE_SYM,
   parameter int               N_IDLE   = paraleloserie_idle_tx_pkg::N_IDLE
) (
   input  logic             clk32f,
   input  logic             reset,
   input  logic [WIDTH-1:0] in,
   input  logic             in_valid,
   output logic             tx_load,
   output logic             out,
   output logic             synced
);
   import paraleloserie_idle_tx_pkg::*;

   localparam int ICW = cnt_bits(N_IDLE + 1);

   tx_state_t        state;
   tx_state_t        state_next;
   logic [ICW-1:0]   idle_cnt;
   logic [ICW-1:0]   idle_cnt_next;
   logic             load_edge;
   logic [WIDTH-1:0] load_data;

   // Upstream data is only taken once the far end has seen the full training run.
   assign load_data = (synced && in_valid) ? in : IDLE_SYM;
   assign tx_load   = load_edge && synced && reset;
   assign synced    = (state == ST_SYNCED);

   piso_shifter #(
      .WIDTH(WIDTH)
   ) u_shifter (
      .clk32f   (clk32f),
      .reset    (reset),
      .load_data(load_data),
      .load_edge(load_edge),
      .out      (out)
   );

   always_ff @(posedge clk32f) begin
      if (!reset) begin
         state    <= ST_TRAIN;
         idle_cnt <= '0;
      end else begin
         state    <= state_next;
         idle_cnt <= idle_cnt_next;
      end
   end

   // Sync is declared on the same edge that loads the last training IDLE.
   always_comb begin
      state_next    = state;
      idle_cnt_next = idle_cnt;
      if (state == ST_TRAIN && load_edge) begin
         idle_cnt_next = idle_cnt + ICW'(1);
         if (idle_cnt_next == ICW'(N_IDLE)) begin
            state_next = ST_SYNCED;
         end
      end
   end

endmodule

// File: tb/tb_paraleloserie_idle_tx.sv
// Self-checking bench for paraleloserie_idle_tx against an edge-index model of the serial stream.
// Each scenario task drives random or directed stimulus and compares out/synced/tx_load inline.
module tb_paraleloserie_idle_tx;

   localparam int         N_IDLE = 4;
   localparam logic [7:0] IDLE   = 8'hBC;

   logic       clk32f   = 1'b0;
   logic       reset    = 1'b0;
   logic [7:0] in_byte  = 8'h00;
   logic       in_valid = 1'b0;
   logic       tx_load;
   logic       out;
   logic       synced;

   int checks = 0;
   int fails  = 0;

   // Model: k is the index of the last rising edge since reset release (-1 while in reset).
   int         k = -1;
   logic [7:0] slot_byte = 8'h00;
   logic       exp_out, exp_synced, exp_txload;
   logic       obs_out, obs_synced, obs_txload;
   logic       last_load;

   paraleloserie_idle_tx dut (
      .clk32f  (clk32f),
      .reset   (reset),
      .in      (in_byte),
      .in_valid(in_valid),
      .tx_load (tx_load),
      .out     (out),
      .synced  (synced)
   );

   always #5 clk32f = ~clk32f;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got timeout exp completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // One bit slot: drive on the falling edge, sample tx_load before the rising edge, outputs after it.
   task automatic applyStimulus(input logic rst, input logic v, input logic [7:0] d);
      @(negedge clk32f);
      reset    = rst;
      in_valid = v;
      in_byte  = d;
      #2;
      obs_txload = tx_load;
      exp_txload = rst && ((k + 1) % 8 == 0) && ((k + 1) / 8 >= N_IDLE);
      @(posedge clk32f);
      #1;
      last_load = 1'b0;
      if (!rst) begin
         k          = -1;
         exp_out    = 1'b0;
         exp_synced = 1'b0;
      end else begin
         k++;
         if (k % 8 == 0) begin
            slot_byte = ((k / 8 >= N_IDLE) && v) ? d : IDLE;
            last_load = 1'b1;
         end
         exp_out    = slot_byte[7 - (k % 8)];
         exp_synced = (k >= 8 * (N_IDLE - 1));
      end
      obs_out    = out;
      obs_synced = synced;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 1'b0, 8'h00);
         checks += 3;
         if (obs_out !== 1'b0) begin fails++; $display("[TB] FAIL reset_out got %b exp 0", obs_out); end
         if (obs_synced !== 1'b0) begin fails++; $display("[TB] FAIL reset_synced got %b exp 0", obs_synced); end
         if (obs_txload !== 1'b0) begin fails++; $display("[TB] FAIL reset_txload got %b exp 0", obs_txload); end
      end
      for (int i = 0; i < 33; i++) begin
         applyStimulus(1'b1, 1'b0, 8'($urandom));
         checks += 3;
         if (obs_out !== exp_out) begin fails++; $display("[TB] FAIL train_out k=%0d got %b exp %b", k, obs_out, exp_out); end
         if (obs_synced !== exp_synced) begin fails++; $display("[TB] FAIL train_synced k=%0d got %b exp %b", k, obs_synced, exp_synced); end
         if (obs_txload !== exp_txload) begin fails++; $display("[TB] FAIL train_txload k=%0d got %b exp %b", k, obs_txload, exp_txload); end
      end
   endtask

   task automatic test_data_a5();
      for (int i = 0; i < 32; i++) begin
         applyStimulus(1'b1, 1'b1, 8'hA5);
         checks += 3;
         if (obs_out !== exp_out) begin fails++; $display("[TB] FAIL a5_out k=%0d got %b exp %b", k, obs_out, exp_out); end
         if (obs_synced !== 1'b1) begin fails++; $display("[TB] FAIL a5_synced k=%0d got %b exp 1", k, obs_synced); end
         if (obs_txload !== exp_txload) begin fails++; $display("[TB] FAIL a5_txload k=%0d got %b exp %b", k, obs_txload, exp_txload); end
      end
   endtask

   task automatic test_alternate();
      for (int i = 0; i < 32; i++) begin
         applyStimulus(1'b1, (((k + 1) / 8) % 2 == 0), 8'h3C);
         checks += 2;
         if (obs_out !== exp_out) begin fails++; $display("[TB] FAIL alt_out k=%0d got %b exp %b", k, obs_out, exp_out); end
         if (obs_txload !== exp_txload) begin fails++; $display("[TB] FAIL alt_txload k=%0d got %b exp %b", k, obs_txload, exp_txload); end
      end
   endtask

   task automatic test_training_ignores_valid();
      applyStimulus(1'b0, 1'b1, 8'hFF);
      checks++;
      if (obs_out !== 1'b0) begin fails++; $display("[TB] FAIL tr_reset_out got %b exp 0", obs_out); end
      for (int i = 0; i < 32; i++) begin
         applyStimulus(1'b1, 1'b1, 8'hFF);
         checks += 3;
         if (obs_out !== IDLE[7 - (i % 8)]) begin fails++; $display("[TB] FAIL tr_out k=%0d got %b exp %b", k, obs_out, IDLE[7 - (i % 8)]); end
         if (obs_synced !== exp_synced) begin fails++; $display("[TB] FAIL tr_synced k=%0d got %b exp %b", k, obs_synced, exp_synced); end
         if (obs_txload !== 1'b0) begin fails++; $display("[TB] FAIL tr_txload k=%0d got %b exp 0", k, obs_txload); end
      end
   endtask

   task automatic test_mid_byte_reset();
      for (int i = 0; i < 64 && !(k >= 8 * N_IDLE && k % 8 == 4); i++) begin
         applyStimulus(1'b1, 1'b1, 8'($urandom));
      end
      checks++;
      if (!(k >= 8 * N_IDLE && k % 8 == 4)) begin
         fails++;
         $display("[TB] FAIL midreset_reach got k=%0d exp data bit 3", k);
      end
      applyStimulus(1'b0, 1'b1, 8'($urandom));
      checks += 2;
      if (obs_out !== 1'b0) begin fails++; $display("[TB] FAIL midreset_out got %b exp 0", obs_out); end
      if (obs_synced !== 1'b0) begin fails++; $display("[TB] FAIL midreset_synced got %b exp 0", obs_synced); end
      for (int i = 0; i < 40; i++) begin
         applyStimulus(1'b1, 1'b1, 8'($urandom));
         checks += 3;
         if (obs_out !== exp_out) begin fails++; $display("[TB] FAIL retrain_out k=%0d got %b exp %b", k, obs_out, exp_out); end
         if (obs_synced !== exp_synced) begin fails++; $display("[TB] FAIL retrain_synced k=%0d got %b exp %b", k, obs_synced, exp_synced); end
         if (obs_txload !== exp_txload) begin fails++; $display("[TB] FAIL retrain_txload k=%0d got %b exp %b", k, obs_txload, exp_txload); end
      end
   endtask

   // Random bytes with random gaps; the serial stream is reassembled into bytes and matched slot by slot.
   task automatic test_back_to_back();
      logic [7:0] sent_q[$];
      logic [7:0] acc;
      logic [7:0] want;
      bit         collecting;
      int         exp_loads;
      int         obs_loads;
      logic [7:0] d;
      logic       v;
      acc        = 8'h00;
      collecting = 1'b0;
      exp_loads  = 0;
      obs_loads  = 0;
      for (int i = 0; i < 96; i++) begin
         d = 8'($urandom);
         v = ($urandom_range(0, 3) != 0);
         applyStimulus(1'b1, v, d);
         if (exp_txload && v) exp_loads++;
         if (obs_txload && v) obs_loads++;
         if (last_load) begin
            sent_q.push_back((exp_txload && v) ? d : IDLE);
            collecting = 1'b1;
         end
         if (collecting) begin
            acc = {acc[6:0], obs_out};
            if (k % 8 == 7) begin
               want = sent_q.pop_front();
               checks++;
               if (acc !== want) begin fails++; $display("[TB] FAIL b2b_byte k=%0d got %h exp %h", k, acc, want); end
            end
         end
      end
      checks++;
      if (obs_loads !== exp_loads) begin fails++; $display("[TB] FAIL b2b_loads got %0d exp %0d", obs_loads, exp_loads); end
   endtask

   initial begin
      $display("[TB] starting paraleloserie_idle_tx bench");
      test_reset();
      test_data_a5();
      test_alternate();
      test_training_ignores_valid();
      test_mid_byte_reset();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
